// File: rtl/gnn_pkg.sv
// Shared constants and types for the GNN input loader: operand geometry,
// loader FSM states and the beat offset of every weight inside w_flat.
package gnn_pkg;

   localparam int DATA_W    = 5;
   localparam int N_FEAT    = 16;
   localparam int N_WGT     = 24;
   localparam int FRAME_LEN = N_FEAT + N_WGT;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      PEND = 2'd1,
      FIRE = 2'd2
   } ld_state_t;

   // Layer-1 weights (inputs 0..3 to hidden 4..7), hidden-major.
   localparam int W_04 = 0;
   localparam int W_14 = 1;
   localparam int W_24 = 2;
   localparam int W_34 = 3;
   localparam int W_05 = 4;
   localparam int W_15 = 5;
   localparam int W_25 = 6;
   localparam int W_35 = 7;
   localparam int W_06 = 8;
   localparam int W_16 = 9;
   localparam int W_26 = 10;
   localparam int W_36 = 11;
   localparam int W_07 = 12;
   localparam int W_17 = 13;
   localparam int W_27 = 14;
   localparam int W_37 = 15;
   // Layer-2 weights (hidden 4..7 to outputs 8..9), output-major.
   localparam int W_48 = 16;
   localparam int W_58 = 17;
   localparam int W_68 = 18;
   localparam int W_78 = 19;
   localparam int W_49 = 20;
   localparam int W_59 = 21;
   localparam int W_69 = 22;
   localparam int W_79 = 23;

endpackage

// File: rtl/gnn_ld_shadow.sv
// Shadow frame buffer: one addressed write port, whole contents exposed in
// parallel so a complete frame can be committed in a single edge.
import gnn_pkg::*;

module gnn_ld_shadow (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          we_i,
   input  logic [5:0]                    addr_i,
   input  logic [DATA_W-1:0]             wdata_i,
   output logic [FRAME_LEN*DATA_W-1:0]   rd_o
);

   logic [FRAME_LEN*DATA_W-1:0] mem_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
      end else if (we_i && (addr_i < 6'(FRAME_LEN))) begin
         mem_q[addr_i*DATA_W +: DATA_W] <= wdata_i;
      end
   end

   assign rd_o = mem_q;

endmodule

// File: rtl/gnn_input_loader.sv
// Serial-to-parallel frame loader feeding the 4-node GNN; double-buffered so
// the next frame streams in while the GNN works. Optional: GNN_LOADER_WGT_HOLD_EN.
import gnn_pkg::*;

module gnn_input_loader (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   input  logic [DATA_W-1:0]           s_data,
   input  logic                        s_last,
   output logic                        s_ready,
   input  logic                        gnn_done,
`ifdef GNN_LOADER_WGT_HOLD_EN
   input  logic                        w_reload,
`endif
   output logic [N_FEAT*DATA_W-1:0]    x_flat,
   output logic [N_WGT*DATA_W-1:0]     w_flat,
   output logic                        in_ready,
   output logic                        busy,
   output logic                        frame_err
);

   ld_state_t                     state_q;
   logic [5:0]                    cnt_q;
   logic                          busy_q;
   logic                          in_ready_q;
   logic                          frame_err_q;
   logic [N_FEAT*DATA_W-1:0]      x_q;
   logic [N_WGT*DATA_W-1:0]       w_q;
   logic [FRAME_LEN*DATA_W-1:0]   shadow_bus;
   logic                          accept;
   logic                          at_last;
   logic                          commit_w;
   logic [5:0]                    last_idx;

   assign accept  = s_valid && (state_q == LOAD);
   assign at_last = (cnt_q == last_idx);

`ifdef GNN_LOADER_WGT_HOLD_EN
   logic wgt_valid_q;
   logic reload_q;
   logic short_q;
   logic short_d;

   // Frame length is decided when beat 0 arrives and frozen for the frame.
   assign short_d  = (cnt_q == 6'd0) ? (wgt_valid_q && !reload_q && !w_reload) : short_q;
   assign last_idx = short_d ? 6'(N_FEAT - 1) : 6'(FRAME_LEN - 1);
   assign commit_w = !short_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wgt_valid_q <= 1'b0;
         reload_q    <= 1'b0;
         short_q     <= 1'b0;
      end else begin
         if (w_reload) reload_q <= 1'b1;
         if (accept && (cnt_q == 6'd0)) begin
            short_q <= short_d;
            if (reload_q || w_reload) begin
               reload_q    <= 1'b0;
               wgt_valid_q <= 1'b0;
            end
         end
         if ((state_q == FIRE) && !short_q) wgt_valid_q <= 1'b1;
      end
   end
`else
   assign last_idx = 6'(FRAME_LEN - 1);
   assign commit_w = 1'b1;
`endif

   gnn_ld_shadow u_shadow (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (accept),
      .addr_i  (cnt_q),
      .wdata_i (s_data),
      .rd_o    (shadow_bus)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         frame_err_q <= 1'b0;
         x_q         <= '0;
         w_q         <= '0;
      end else begin
         in_ready_q  <= 1'b0;
         frame_err_q <= 1'b0;
         if (busy_q && gnn_done) busy_q <= 1'b0;
         case (state_q)
            LOAD: begin
               if (accept) begin
                  if (s_last && at_last) begin
                     cnt_q   <= '0;
                     state_q <= busy_q ? PEND : FIRE;
                  end else if (s_last || at_last) begin
                     // Length/marker disagreement: drop the frame and resync.
                     cnt_q       <= '0;
                     frame_err_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 6'd1;
                  end
               end
            end
            PEND: begin
               if (!busy_q) state_q <= FIRE;
            end
            FIRE: begin
               state_q    <= LOAD;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b1;
               x_q        <= shadow_bus[N_FEAT*DATA_W-1:0];
               if (commit_w) w_q <= shadow_bus[FRAME_LEN*DATA_W-1:N_FEAT*DATA_W];
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign s_ready   = (state_q == LOAD);
   assign x_flat    = x_q;
   assign w_flat    = w_q;
   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_gnn_input_loader.sv
// Directed bench for gnn_input_loader: commit latency, PEND hand-off, framing
// errors, mid-frame reset and (with GNN_LOADER_WGT_HOLD_EN) weight hold.
module tb_gnn_input_loader;
   import gnn_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        s_valid = 1'b0;
   logic [DATA_W-1:0]           s_data = '0;
   logic                        s_last = 1'b0;
   logic                        gnn_done = 1'b0;
   logic                        s_ready, in_ready, busy, frame_err;
   logic [N_FEAT*DATA_W-1:0]    x_flat;
   logic [N_WGT*DATA_W-1:0]     w_flat;
`ifdef GNN_LOADER_WGT_HOLD_EN
   logic                        w_reload = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W-1:0]           vals [FRAME_LEN];
   logic [N_FEAT*DATA_W-1:0]    exp_x = '0;
   logic [N_WGT*DATA_W-1:0]     exp_w = '0;

   always #5 clk = ~clk;

   gnn_input_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .gnn_done  (gnn_done),
`ifdef GNN_LOADER_WGT_HOLD_EN
      .w_reload  (w_reload),
`endif
      .x_flat    (x_flat),
      .w_flat    (w_flat),
      .in_ready  (in_ready),
      .busy      (busy),
      .frame_err (frame_err)
   );

   task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill(input int mul, input int add);
      for (int k = 0; k < FRAME_LEN; k++) vals[k] = DATA_W'(mul * k + add);
   endtask

   task automatic set_exp(input bit with_w);
      logic [199:0] r;
      r = '0;
      for (int k = 0; k < FRAME_LEN; k++) r[k*DATA_W +: DATA_W] = vals[k];
      exp_x = r[N_FEAT*DATA_W-1:0];
      if (with_w) exp_w = r[FRAME_LEN*DATA_W-1:N_FEAT*DATA_W];
   endtask

   // Streams n beats from vals[]; s_last on beat last_at (-1: never).
   task automatic send(input int n, input int last_at);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("s_ready_beat", s_ready, 1);
         s_valid = 1'b1;
         s_data  = vals[k];
         s_last  = (k == last_at);
         @(posedge clk);
      end
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic expect_commit(input string tag);
      @(negedge clk);
      chk({tag, "_ir_e0"}, in_ready, 0);
      chk({tag, "_srdy_fire"}, s_ready, 0);
      @(negedge clk);
      chk({tag, "_ir_e1"}, in_ready, 1);
      chk({tag, "_x"}, x_flat, exp_x);
      chk({tag, "_w"}, w_flat, exp_w);
      chk({tag, "_srdy_after"}, s_ready, 1);
      @(negedge clk);
      chk({tag, "_ir_e2"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 1);
   endtask

   task automatic expect_err(input string tag);
      @(negedge clk);
      chk({tag, "_ferr1"}, frame_err, 1);
      chk({tag, "_ir"}, in_ready, 0);
      @(negedge clk);
      chk({tag, "_ferr0"}, frame_err, 0);
      chk({tag, "_ir2"}, in_ready, 0);
      chk({tag, "_x_hold"}, x_flat, exp_x);
      chk({tag, "_w_hold"}, w_flat, exp_w);
      chk({tag, "_srdy"}, s_ready, 1);
   endtask

   task automatic release_gnn();
      @(negedge clk);
      gnn_done = 1'b1;
      @(posedge clk);
      #1 gnn_done = 1'b0;
      @(negedge clk);
      chk("busy_clear", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_x", x_flat, 0);
      chk("rst_w", w_flat, 0);
      rst_n = 1'b1;

      // Frame A: k-20, GNN idle.
      fill(1, -20);
      send(40, 39);
      set_exp(1);
      expect_commit("A");
      chk("A_x_slot0", x_flat[4:0], 5'b01100);
      chk("A_w_slot23", w_flat[23*DATA_W +: DATA_W], 5'b10011);

      // Frame B while busy: parks in PEND until gnn_done.
      fill(3, 7);
      send(40, 39);
      repeat (3) begin
         @(negedge clk);
         chk("B_pend_srdy", s_ready, 0);
         chk("B_pend_ir", in_ready, 0);
         chk("B_pend_x", x_flat, exp_x);
         chk("B_pend_busy", busy, 1);
      end
      gnn_done = 1'b1;
      @(posedge clk);
      #1 gnn_done = 1'b0;
      @(negedge clk);
      chk("B_busy_d", busy, 0);
      chk("B_ir_d", in_ready, 0);
      set_exp(1);
      @(negedge clk);
      chk("B_ir_d1", in_ready, 0);
      chk("B_srdy_fire", s_ready, 0);
      @(negedge clk);
      chk("B_ir_d2", in_ready, 1);
      chk("B_x", x_flat, exp_x);
      chk("B_w", w_flat, exp_w);
      @(negedge clk);
      chk("B_ir_off", in_ready, 0);
      release_gnn();
      // A stray gnn_done while idle is ignored.
      gnn_done = 1'b1;
      @(posedge clk);
      #1 gnn_done = 1'b0;
      @(negedge clk);
      chk("idle_done_busy", busy, 0);
      chk("idle_done_ir", in_ready, 0);

      // Early s_last on beat 10, then a clean frame C.
      fill(-1, 5);
      send(11, 10);
      expect_err("early_last");
      send(40, 39);
      set_exp(1);
      expect_commit("C");
      release_gnn();

      // 40 beats without s_last; the 41st beat starts frame D.
      fill(9, 2);
      send(40, -1);
      expect_err("no_last");
      fill(5, -3);
      send(40, 39);
      set_exp(1);
      expect_commit("D");

      // Reset during beat 20 (GNN still busy with D).
      fill(7, 1);
      send(20, -1);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = vals[20];
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_x", x_flat, 0);
      chk("mrst_w", w_flat, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ir", in_ready, 0);
      chk("mrst_srdy", s_ready, 1);
      s_valid = 1'b0;
      exp_x = '0;
      exp_w = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("mrst_no_ir", in_ready, 0);
         chk("mrst_ferr", frame_err, 0);
      end
      send(40, 39);
      set_exp(1);
      expect_commit("E");
      release_gnn();

`ifdef GNN_LOADER_WGT_HOLD_EN
      // Weights held: a 16-beat frame updates only x_flat.
      fill(2, -9);
      send(16, 15);
      set_exp(0);
      expect_commit("F_short");
      release_gnn();
      @(negedge clk);
      w_reload = 1'b1;
      @(posedge clk);
      #1 w_reload = 1'b0;
      send(16, 15);
      expect_err("reload_short");
      fill(-3, 11);
      send(40, 39);
      set_exp(1);
      expect_commit("G");
      release_gnn();
`else
      // Every frame is 40 beats: a 16-beat frame is a framing error.
      fill(2, -9);
      send(16, 15);
      expect_err("short16");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
